rx_correlator_param: RTL and testbench

Parametrised, handshake-driven successor to the fixed 16-sequence, 20-sample receive correlator. Each bit-period beat carries N_PAR parallel chip products. The block sums them, then adds or subtracts the sum into NUM_SEQ accumulators according to the per-sequence code bits. After SEQ_LEN beats it runs a sequential arg-max search over the accumulator magnitudes and reports the best sequence, its magnitude and a threshold detect flag. It sits between the correlation units / sequence bit feeder and the packet detection logic.

---
 rtl/rx_corr_pkg.sv | 43 ++++
 rtl/rx_corr_adder_tree.sv | 42 ++++
 rtl/rx_correlator_param.sv | 189 ++++++++++++++++++
 tb/tb_rx_correlator_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_corr_pkg.sv
// Shared definitions for the parametrised receive correlator:
// width helpers, default derived widths and the FSM state encoding.
package rx_corr_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

  // Signed width of one beat sum (N_PAR products of SAMPLE_W bits).
  function automatic int unsigned calc_sum_w(input int unsigned sample_w,
                                             input int unsigned n_par);
    return sample_w + clog2(n_par);
  endfunction

  // Accumulator width; the extra bit keeps negation of the most-negative
  // beat sum representable over a full window.
  function automatic int unsigned calc_acc_w(input int unsigned sample_w,
                                             input int unsigned n_par,
                                             input int unsigned seq_len);
    return calc_sum_w(sample_w, n_par) + clog2(seq_len) + 1;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  // Widths for the default configuration (16 seq, 20 x 17-bit, 32 beats).
  localparam int unsigned DEF_SUM_W = calc_sum_w(17, 20);
  localparam int unsigned DEF_ACC_W = calc_acc_w(17, 20, 32);
  localparam int unsigned DEF_IDX_W = calc_idx_w(16);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/rx_corr_adder_tree.sv
// Registered sum of N_PAR signed SAMPLE_W chip products, sign-extended to
// SUM_W, with a valid bit travelling alongside. One cycle latency.
// Ports: clk, clear (sync, drops valid and sum), in_valid, samples
// (element k at [k*SAMPLE_W +: SAMPLE_W]), out_valid, sum.
module rx_corr_adder_tree
  import rx_corr_pkg::*;
#(
  parameter int unsigned N_PAR    = 20,
  parameter int unsigned SAMPLE_W = 17,
  parameter int unsigned SUM_W    = calc_sum_w(SAMPLE_W, N_PAR)
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [N_PAR*SAMPLE_W-1:0] samples,
  output logic                      out_valid,
  output logic signed [SUM_W-1:0]   sum
);

  logic signed [SAMPLE_W-1:0] elem;
  logic signed [SUM_W-1:0]    total;

  always_comb begin
    elem  = '0;
    total = '0;
    for (int unsigned k = 0; k < N_PAR; k++) begin
      elem  = samples[k*SAMPLE_W +: SAMPLE_W];
      total = total + SUM_W'(elem);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else begin
      out_valid <= in_valid;
      sum       <= total;
    end
  end

endmodule

// File: rtl/rx_correlator_param.sv
// Parametrised receive correlator. Each accepted beat's chip products are
// summed, then added to / subtracted from NUM_SEQ accumulators by the
// per-sequence code bits. After SEQ_LEN beats a sequential arg-max over
// |acc| reports the best sequence, its magnitude and a threshold detect.
// Ports: crx_clk, rrx_rst (sync, active high), erx_en (low = sync clear),
// istart, ibit_valid, isamples, iseq_bits, ithreshold; outputs
// ocorrelation (packed accumulators), obest_idx, obest_mag, odetect,
// odone (1-cycle result pulse), obusy.
module rx_correlator_param
  import rx_corr_pkg::*;
#(
  parameter int unsigned NUM_SEQ  = 16,
  parameter int unsigned N_PAR    = 20,
  parameter int unsigned SAMPLE_W = 17,
  parameter int unsigned SEQ_LEN  = 32,
  localparam int unsigned SUM_W   = calc_sum_w(SAMPLE_W, N_PAR),
  localparam int unsigned ACC_W   = calc_acc_w(SAMPLE_W, N_PAR, SEQ_LEN),
  localparam int unsigned IDX_W   = calc_idx_w(NUM_SEQ)
) (
  input  logic                      crx_clk,
  input  logic                      rrx_rst,
  input  logic                      erx_en,
  input  logic                      istart,
  input  logic                      ibit_valid,
  input  logic [N_PAR*SAMPLE_W-1:0] isamples,
  input  logic [NUM_SEQ-1:0]        iseq_bits,
  input  logic [ACC_W-2:0]          ithreshold,
  output logic [NUM_SEQ*ACC_W-1:0]  ocorrelation,
  output logic [IDX_W-1:0]          obest_idx,
  output logic [ACC_W-1:0]          obest_mag,
  output logic                      odetect,
  output logic                      odone,
  output logic                      obusy
);

  localparam int unsigned CNT_W = calc_idx_w(SEQ_LEN);

  state_t state, state_nxt;

  logic clear;
  logic flush;
  logic accept;
  logic last_beat;

  logic [CNT_W-1:0] beat_cnt;
  logic             drain_cnt;
  logic [IDX_W-1:0] scan;
  logic             scan_last;

  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [NUM_SEQ-1:0]      s1_bits;
  logic signed [ACC_W-1:0] sum_ext;

  logic signed [ACC_W-1:0] acc [NUM_SEQ];

  logic signed [ACC_W-1:0] cur_acc;
  logic [ACC_W-1:0]        cur_mag;
  logic [IDX_W-1:0]        run_idx;
  logic [ACC_W-1:0]        run_mag;

  // istart aborts from any state and clears like a reset, except the FSM
  // then heads to ACCUM instead of IDLE.
  assign clear     = rrx_rst | ~erx_en;
  assign flush     = clear | istart;
  assign accept    = (state == ACCUM) & ibit_valid & ~istart;
  assign last_beat = accept & (beat_cnt == CNT_W'(SEQ_LEN - 1));
  assign scan_last = (scan == IDX_W'(NUM_SEQ - 1));
  assign sum_ext   = ACC_W'(s1_sum);

  // Stage 1: beat sum; code bits delayed to stay aligned with it.
  rx_corr_adder_tree #(
    .N_PAR    (N_PAR),
    .SAMPLE_W (SAMPLE_W),
    .SUM_W    (SUM_W)
  ) u_adder_tree (
    .clk       (crx_clk),
    .clear     (flush),
    .in_valid  (accept),
    .samples   (isamples),
    .out_valid (s1_valid),
    .sum       (s1_sum)
  );

  always_ff @(posedge crx_clk) begin
    if (flush) begin
      s1_bits <= '0;
    end else if (accept) begin
      s1_bits <= iseq_bits;
    end
  end

  // Stage 2: accumulator bank.
  always_ff @(posedge crx_clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < NUM_SEQ; i++) acc[i] <= '0;
    end else if (s1_valid) begin
      for (int unsigned i = 0; i < NUM_SEQ; i++) begin
        acc[i] <= s1_bits[i] ? acc[i] + sum_ext : acc[i] - sum_ext;
      end
    end
  end

  always_comb begin
    ocorrelation = '0;
    for (int unsigned i = 0; i < NUM_SEQ; i++) begin
      ocorrelation[i*ACC_W +: ACC_W] = acc[i];
    end
  end

  // FSM
  always_ff @(posedge crx_clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = IDLE;
      ACCUM:   if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = SEARCH;
      SEARCH:  if (scan_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (istart) state_nxt = ACCUM;
  end

  always_comb begin
    obusy = (state != IDLE);
  end

  // Magnitude of the accumulator under the scan pointer.
  always_comb begin
    cur_acc = acc[scan];
    cur_mag = cur_acc[ACC_W-1] ? -cur_acc : cur_acc;
  end

  // Beat counter, drain timer and running arg-max.
  always_ff @(posedge crx_clk) begin
    if (flush) begin
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
      scan      <= '0;
      run_idx   <= '0;
      run_mag   <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == DRAIN) begin
        scan    <= '0;
        run_idx <= '0;
        run_mag <= '0;
      end else if (state == SEARCH) begin
        // Strict compare: earlier index keeps a tie.
        if (cur_mag > run_mag) begin
          run_idx <= scan;
          run_mag <= cur_mag;
        end
        scan <= scan_last ? '0 : scan + 1'b1;
      end
    end
  end

  // Results are published on the edge leaving DONE, so odone lands
  // NUM_SEQ+3 edges after the last accepted beat.
  always_ff @(posedge crx_clk) begin
    if (flush) begin
      obest_idx <= '0;
      obest_mag <= '0;
      odetect   <= 1'b0;
      odone     <= 1'b0;
    end else begin
      odone <= (state == DONE);
      if (state == DONE) begin
        obest_idx <= run_idx;
        obest_mag <= run_mag;
        odetect   <= (run_mag >= ACC_W'(ithreshold));
      end
    end
  end

endmodule

// File: tb/tb_rx_correlator_param.sv
// Scoreboard bench for rx_correlator_param (4 seq, 2 x 16-bit, 4 beats).
module tb_rx_correlator_param;

  localparam int unsigned NS = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned SW = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned AW = 20;
  localparam int unsigned IW = 2;

  logic             crx_clk    = 1'b0;
  logic             rrx_rst    = 1'b1;
  logic             erx_en     = 1'b1;
  logic             istart     = 1'b0;
  logic             ibit_valid = 1'b0;
  logic [NP*SW-1:0] isamples   = '0;
  logic [NS-1:0]    iseq_bits  = '0;
  logic [AW-2:0]    ithreshold = '0;
  logic [NS*AW-1:0] ocorrelation;
  logic [IW-1:0]    obest_idx;
  logic [AW-1:0]    obest_mag;
  logic             odetect;
  logic             odone;
  logic             obusy;

  rx_correlator_param #(
    .NUM_SEQ  (NS),
    .N_PAR    (NP),
    .SAMPLE_W (SW),
    .SEQ_LEN  (SL)
  ) dut (
    .crx_clk      (crx_clk),
    .rrx_rst      (rrx_rst),
    .erx_en       (erx_en),
    .istart       (istart),
    .ibit_valid   (ibit_valid),
    .isamples     (isamples),
    .iseq_bits    (iseq_bits),
    .ithreshold   (ithreshold),
    .ocorrelation (ocorrelation),
    .obest_idx    (obest_idx),
    .obest_mag    (obest_mag),
    .odetect      (odetect),
    .odone        (odone),
    .obusy        (obusy)
  );

  typedef struct packed {
    logic [IW-1:0]    idx;
    logic [AW-1:0]    mag;
    logic             det;
    logic [NS*AW-1:0] corr;
    logic [31:0]      done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [SW-1:0] w_s0   [SL];
  logic [SW-1:0] w_s1   [SL];
  logic [NS-1:0] w_bits [SL];
  int            w_gap  [SL];

  always #5 crx_clk = ~crx_clk;
  always @(posedge crx_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint corr_at(input int i);
    logic signed [AW-1:0] v;
    v = ocorrelation[i*AW +: AW];
    return longint'(v);
  endfunction

  // Result monitor: pops the scoreboard whenever the DUT reports a result.
  always @(negedge crx_clk) begin
    if (odone) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc, longint'(mon_e.done_cyc));
        check("best_idx", obest_idx, mon_e.idx);
        check("best_mag", obest_mag, mon_e.mag);
        check("detect", odetect, mon_e.det);
        for (int i = 0; i < NS; i++) begin
          logic signed [AW-1:0] ev;
          ev = mon_e.corr[i*AW +: AW];
          check($sformatf("corr%0d", i), corr_at(i), longint'(ev));
        end
      end
    end
  end

  task automatic tick();
    @(posedge crx_clk);
    #1;
  endtask

  task automatic beat(input logic [SW-1:0] a, input logic [SW-1:0] b,
                      input logic [NS-1:0] bits);
    ibit_valid = 1'b1;
    isamples   = {b, a};
    iseq_bits  = bits;
    tick();
    ibit_valid = 1'b0;
  endtask

  task automatic fill(input logic [SW-1:0] a, input logic [SW-1:0] b,
                      input logic [NS-1:0] bits);
    for (int k = 0; k < SL; k++) begin
      w_s0[k]   = a;
      w_s1[k]   = b;
      w_bits[k] = bits;
      w_gap[k]  = 0;
    end
  endtask

  // Drives one window from the w_* tables and pushes its expected result.
  // dirty: a junk beat rides along with istart and must be discarded.
  task automatic run_window(input bit dirty);
    longint               acc [NS];
    longint               sum, m, best;
    int                   bi;
    logic signed [SW-1:0] a, b;
    exp_t                 e;
    for (int i = 0; i < NS; i++) acc[i] = 0;
    istart = 1'b1;
    if (dirty) begin
      ibit_valid = 1'b1;
      isamples   = {16'h7fff, 16'h7fff};
      iseq_bits  = '1;
    end
    tick();
    istart     = 1'b0;
    ibit_valid = 1'b0;
    for (int k = 0; k < SL; k++) begin
      repeat (w_gap[k]) tick();
      beat(w_s0[k], w_s1[k], w_bits[k]);
      a   = w_s0[k];
      b   = w_s1[k];
      sum = longint'(a) + longint'(b);
      for (int i = 0; i < NS; i++) acc[i] = w_bits[k][i] ? acc[i] + sum : acc[i] - sum;
    end
    e.done_cyc = 32'(cyc + NS + 3);
    best = 0;
    bi   = 0;
    for (int i = 0; i < NS; i++) begin
      m = (acc[i] < 0) ? -acc[i] : acc[i];
      if (m > best) begin
        best = m;
        bi   = i;
      end
    end
    e.idx  = IW'(bi);
    e.mag  = AW'(best);
    e.det  = (best >= longint'(ithreshold));
    e.corr = '0;
    for (int i = 0; i < NS; i++) e.corr[i*AW +: AW] = acc[i][AW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("result_arrived", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", obusy, 0);
    check("rst_done", odone, 0);
    check("rst_mag", obest_mag, 0);
    rrx_rst = 1'b0;
    tick();

    // Reset mid-window, then beats while idle must not accumulate.
    fill(16'd100, 16'd100, 4'b0101);
    istart = 1'b1;
    tick();
    istart = 1'b0;
    beat(16'd100, 16'd100, 4'b0101);
    beat(16'd100, 16'd100, 4'b0101);
    tick();
    check("pre_rst_corr0", corr_at(0), 400);
    rrx_rst = 1'b1;
    tick();
    rrx_rst = 1'b0;
    check("mid_rst_busy", obusy, 0);
    check("mid_rst_done", odone, 0);
    check("mid_rst_idx", obest_idx, 0);
    check("mid_rst_det", odetect, 0);
    for (int i = 0; i < NS; i++) check($sformatf("mid_rst_corr%0d", i), corr_at(i), 0);
    repeat (3) beat(16'd55, 16'd66, 4'b1111);
    tick();
    for (int i = 0; i < NS; i++) check($sformatf("idle_corr%0d", i), corr_at(i), 0);
    check("idle_busy", obusy, 0);

    // Basic window.
    ithreshold = '0;
    fill(16'd100, 16'd100, 4'b0101);
    run_window(1'b0);
    wait_idle();
    check("basic_idx", obest_idx, 0);
    check("basic_mag", obest_mag, 800);
    check("basic_corr0", corr_at(0), 800);
    check("basic_corr3", corr_at(3), -800);

    // Threshold boundary.
    ithreshold = 19'd800;
    run_window(1'b0);
    wait_idle();
    check("thr800_det", odetect, 1);
    ithreshold = 19'd801;
    run_window(1'b0);
    wait_idle();
    check("thr801_det", odetect, 0);

    // Width extreme.
    ithreshold = 19'd262145;
    fill(16'h8000, 16'h8000, 4'b0000);
    run_window(1'b0);
    wait_idle();
    check("ext_mag", obest_mag, 262144);
    check("ext_corr2", corr_at(2), 262144);
    check("ext_det", odetect, 0);

    // Abort after two beats; restart carries a discarded beat.
    istart = 1'b1;
    tick();
    istart = 1'b0;
    beat(16'd900, 16'd900, 4'b1111);
    beat(16'd900, 16'd900, 4'b1111);
    ithreshold = 19'd12;
    fill(16'd1, 16'd2, 4'b1000);
    run_window(1'b1);
    wait_idle();
    check("abort_idx", obest_idx, 0);
    check("abort_mag", obest_mag, 12);
    check("abort_corr3", corr_at(3), 12);
    check("abort_corr1", corr_at(1), -12);

    // Same random data back-to-back, then gapped 0/3/7.
    for (int k = 0; k < SL; k++) begin
      w_s0[k]   = SW'($urandom);
      w_s1[k]   = SW'($urandom);
      w_bits[k] = NS'($urandom);
      w_gap[k]  = 0;
    end
    ithreshold = 19'($urandom_range(0, 140000));
    run_window(1'b0);
    wait_idle();
    w_gap[2] = 3;
    w_gap[3] = 7;
    run_window(1'b0);
    wait_idle();

    // A few fully random windows.
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < SL; k++) begin
        w_s0[k]   = SW'($urandom);
        w_s1[k]   = SW'($urandom);
        w_bits[k] = NS'($urandom);
        w_gap[k]  = $urandom_range(0, 4);
      end
      ithreshold = 19'($urandom_range(0, 270000));
      run_window(1'b0);
      wait_idle();
    end

    // erx_en drop during SEARCH: everything clears, no result.
    fill(16'd100, 16'd100, 4'b0101);
    istart = 1'b1;
    tick();
    istart = 1'b0;
    for (int k = 0; k < SL; k++) beat(16'd100, 16'd100, 4'b0101);
    repeat (4) tick();
    check("pre_en_busy", obusy, 1);
    check("pre_en_corr0", corr_at(0), 800);
    erx_en = 1'b0;
    tick();
    erx_en = 1'b1;
    check("en_busy", obusy, 0);
    check("en_done", odone, 0);
    check("en_mag", obest_mag, 0);
    for (int i = 0; i < NS; i++) check($sformatf("en_corr%0d", i), corr_at(i), 0);
    repeat (20) tick();
    check("en_no_result", exp_q.size(), 0);
    check("en_idle_busy", obusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
